ram_line_reader: RTL and testbench



---
 rtl/ram_line_reader.sv | 140 ++++++++++++++
 tb/tb_ram_line_reader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_line_reader.sv
// Streams a run of lines out of the line RAM: command in, registered RAM reads, 2-entry skid FIFO, valid/ready out.
// Optional macro RLR_STALL_CNT_EN enables the backpressure counter on stall_cycles (tied to 0 otherwise).
module ram_line_reader #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, issued_q, beats_q, cmd_len_clamped;
  logic              inflight_q, done_q, done_d;
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, occ;
  logic              accept, issue, pop, push, pop_fifo, fifo_empty;

  assign cmd_ready       = (state_q == S_IDLE) && !rst;
  assign accept          = cmd_valid && cmd_ready;
  assign cmd_len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  // An in-flight read is presented straight from the RAM port when the FIFO
  // is empty, so the first beat appears the cycle after its issue.
  assign fifo_empty = (count_q == 2'd0);
  assign out_valid  = !fifo_empty || inflight_q;
  assign out_data   = fifo_empty ? ram_r_data : mem_q[rd_ptr_q];
  assign out_last   = out_valid && (beats_q == len_q - LEN_W'(1));
  assign pop        = out_valid && out_ready;
  assign push       = inflight_q && !(fifo_empty && out_ready);
  assign pop_fifo   = pop && !fifo_empty;

  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign occ        = count_q + {1'b0, inflight_q};
  assign issue      = (state_q == S_RUN) && (issued_q < len_q) &&
                      ((occ - {1'b0, pop}) < 2'd2);
  assign ram_r_en   = issue;
  assign ram_r_addr = addr_q;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issued_q + LEN_W'(1) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len_clamped;
        issued_q <= '0;
        beats_q  <= '0;
      end
      if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + LEN_W'(1);
      end
      if (pop) beats_q <= beats_q + LEN_W'(1);
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop_fifo})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Line storage needs no reset; count_q alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ram_r_data;
  end

`ifdef RLR_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 stall_q <= '0;
    else if (accept)                                         stall_q <= '0;
    else if (out_valid && !out_ready && (stall_q != '1))     stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_line_reader.sv
// Directed bench for ram_line_reader with a registered-read RAM model where line k holds k replicated.
module tb_ram_line_reader;
  localparam int DATA_W = 1024;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 10;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_r_addr;
  logic [DATA_W-1:0] ram_r_data;
  logic              out_valid, out_ready, out_last, busy, done;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       stall_cycles;

  int checks   = 0;
  int failures = 0;

  ram_line_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {32{32'(a)}};
  endfunction

  initial ram_r_data = '0;
  always @(posedge clk) if (ram_r_en) ram_r_data <= line_of(ram_r_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_ram_r_en"}, ram_r_en, 0);
    chk({tag, "_ram_r_addr"}, ram_r_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stall"}, stall_cycles, 0);
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  // abort_at > 0: assert rst right after that many beats have been accepted.
  task automatic run_cmd(input int addr, input int len, input int mode, input int abort_at);
    int  eff, issued, beats, stalls, last_pop, done_cyc;
    bit  got_done;
    int  pop;
    eff = (len > 512) ? 512 : len;
    issued = 0; beats = 0; stalls = 0; last_pop = 0; done_cyc = 0; got_done = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = ADDR_W'(addr); cmd_len = LEN_W'(len); out_ready = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_len = '0;
    for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      out_ready = (mode == 0) ? 1'b1 : ((((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3));
      @(negedge clk);
      pop = int'(out_valid && out_ready);
      if (cyc == 1) begin
        chk("first_issue", ram_r_en, eff != 0);
        chk("no_valid_T1", out_valid, 0);
      end
      if (ram_r_en) begin
        chk("issue_addr", ram_r_addr, (addr + issued) % 512);
        chk("issue_room", (issued - beats - pop) < 2, 1);
        issued++;
      end
      if (out_valid) begin
        chk("data_lo", out_data[31:0], (addr + beats) % 512);
        chk("data_full", out_data === line_of(ADDR_W'((addr + beats) % 512)), 1);
        chk("last_flag", out_last, beats == eff - 1);
        if (!out_ready) stalls++;
      end
      if (pop != 0) begin beats++; last_pop = cyc; end
      if (abort_at > 0 && beats == abort_at) begin
        rst = 1'b1;
        #1;
        chk_reset_outputs("midop_rst");
        return;
      end
      if (done) begin got_done = 1; done_cyc = cyc; end
    end
    if (!got_done) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_after_last", done_cyc, (eff == 0) ? 1 : last_pop + 1);
    if (mode == 0) chk("throughput", done_cyc, (eff == 0) ? 1 : eff + 2);
    chk("beat_count", beats, eff);
    chk("issue_count", issued, eff);
    chk("cmd_ready_done", cmd_ready, 1);
    chk("busy_done", busy, 0);
`ifdef RLR_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, stalls);
`else
    chk("stall_cycles", stall_cycles, 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    run_cmd(10, 4, 0, 0);      // basic
    run_cmd(510, 4, 0, 0);     // wrap 510,511,0,1
    run_cmd(20, 8, 1, 0);      // backpressure
    run_cmd(508, 8, 1, 0);     // backpressure across the wrap
    run_cmd(100, 0, 0, 0);     // zero length
    run_cmd(300, 600, 0, 0);   // clamped to 512
    run_cmd(50, 16, 0, 3);     // reset after 3 beats
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(0, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
